// File: rtl/univ_shift_reg_if.sv
// Purpose : bundles the control, data and status signals of univ_shift_reg.
// Latency : none, wiring only.
// Backpressure: none; the en field is the only throttle on the register.
// Ports   : master drives en/mode/d/sin_l/sin_r/burst_start/burst_len and
//           observes q/sout_l/sout_r/busy/done; slave is the register side.
interface univ_shift_reg_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
);
   logic             en;
   logic [2:0]       mode;
   logic [WIDTH-1:0] d;
   logic             sin_l;
   logic             sin_r;
   logic             burst_start;
   logic [CNT_W-1:0] burst_len;
   logic [WIDTH-1:0] q;
   logic             sout_l;
   logic             sout_r;
   logic             busy;
   logic             done;

   modport master (
      output en, mode, d, sin_l, sin_r, burst_start, burst_len,
      input  q, sout_l, sout_r, busy, done
   );

   modport slave (
      input  en, mode, d, sin_l, sin_r, burst_start, burst_len,
      output q, sout_l, sout_r, busy, done
   );
endinterface

// File: rtl/univ_shift_reg.sv
// Purpose : universal shift register (hold/load/shift/rotate/zero) with an
//           autonomous N-step burst sequencer reporting busy and done.
// Latency : 1 cycle per step; an N-step burst ends N edges after acceptance.
// Backpressure: en=0 freezes register and sequencer, pausing a burst.
// Ports   : clk, clear (sync active-low), bus (univ_shift_reg_if.slave):
//           en, mode, d, sin_l, sin_r, burst_start, burst_len in;
//           q, sout_l, sout_r, busy, done out.
// Build option: define UNIV_SHREG_ROTATE_EN to enable modes 100/101 (rotate);
//           otherwise they decode as hold and cannot start a burst.
module univ_shift_reg #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input logic              clk,
   input logic              clear,
   univ_shift_reg_if.slave  bus
);

   localparam logic [2:0] MODE_HOLD = 3'b000;
   localparam logic [2:0] MODE_LOAD = 3'b001;
   localparam logic [2:0] MODE_SHL  = 3'b010;
   localparam logic [2:0] MODE_SHR  = 3'b011;
   localparam logic [2:0] MODE_ROL  = 3'b100;
   localparam logic [2:0] MODE_ROR  = 3'b101;
   localparam logic [2:0] MODE_ZERO = 3'b110;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [CNT_W-1:0] rem_q, rem_d;
   logic [2:0]       op_q, op_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   // One register step for a given operation code.
   function automatic logic [WIDTH-1:0] step_fn(
      input logic [2:0]       op,
      input logic [WIDTH-1:0] cur,
      input logic [WIDTH-1:0] din,
      input logic             sl,
      input logic             sr
   );
      logic [WIDTH-1:0] r;
      r = cur;
      case (op)
         MODE_LOAD: r = din;
         MODE_SHL:  r = {cur[WIDTH-2:0], sr};
         MODE_SHR:  r = {sl, cur[WIDTH-1:1]};
`ifdef UNIV_SHREG_ROTATE_EN
         MODE_ROL:  r = {cur[WIDTH-2:0], cur[WIDTH-1]};
         MODE_ROR:  r = {cur[0], cur[WIDTH-1:1]};
`endif
         MODE_ZERO: r = '0;
         default:   r = cur;  // hold, reserved, and rotate when compiled out
      endcase
      return r;
   endfunction

   // Only shift (and rotate, when present) codes may start a burst.
   function automatic logic burst_ok(input logic [2:0] op);
      logic ok;
      ok = (op == MODE_SHL) || (op == MODE_SHR);
`ifdef UNIV_SHREG_ROTATE_EN
      ok = ok || (op == MODE_ROL) || (op == MODE_ROR);
`endif
      return ok;
   endfunction

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      rem_d   = rem_q;
      op_d    = op_q;
      busy_d  = busy_q;
      done_d  = 1'b0;  // done is a single-cycle pulse, even across en=0

      if (bus.en) begin
         case (state_q)
            IDLE: begin
               if (bus.burst_start && burst_ok(bus.mode)) begin
                  op_d = bus.mode;
                  if (bus.burst_len == '0) begin
                     // Zero-length burst: no movement, just report completion.
                     done_d = 1'b1;
                  end else begin
                     // The accept edge already performs the first step.
                     data_d = step_fn(bus.mode, data_q, bus.d, bus.sin_l, bus.sin_r);
                     if (bus.burst_len == CNT_W'(1)) begin
                        done_d = 1'b1;
                     end else begin
                        rem_d   = bus.burst_len - CNT_W'(1);
                        state_d = BURST;
                        busy_d  = 1'b1;
                     end
                  end
               end else begin
                  data_d = step_fn(bus.mode, data_q, bus.d, bus.sin_l, bus.sin_r);
               end
            end
            BURST: begin
               // Latched op; serial inputs are still sampled live.
               data_d = step_fn(op_q, data_q, bus.d, bus.sin_l, bus.sin_r);
               rem_d  = rem_q - CNT_W'(1);
               if (rem_q == CNT_W'(1)) begin
                  state_d = IDLE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end
            end
            default: begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!clear) begin
         state_q <= IDLE;
         data_q  <= '0;
         rem_q   <= '0;
         op_q    <= MODE_HOLD;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         rem_q   <= rem_d;
         op_q    <= op_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.q      = data_q;
   assign bus.sout_l = data_q[WIDTH-1];
   assign bus.sout_r = data_q[0];
   assign bus.busy   = busy_q;
   assign bus.done   = done_q;

endmodule
